updn_cmd_gen: RTL and testbench
===============================

UPDN_CMD_GEN -- requirements
Module: updn_cmd_gen

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1).
REQ-002 Parameter: RPT_DELAY, 8, cycles from the first pulse of a held button to its first auto-repeat pulse (>=2).
REQ-003 Parameter: RPT_RATE, 3, cycles between successive auto-repeat pulses (>=2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_up / btn_dn / btn_ld  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 sw_in  input  5  load value from switches, quasi-static.
REQ-008 high / low  input  1 each  limit flags returned by the downstream up/down counter.
REQ-009 up / down / load  output  1 each  registered single-cycle command pulses to the counter.
REQ-010 in_val  output  5  registered load value; valid in the cycle load=1.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a per-button debounce counter; the debounced level SHALL change only after DB_CYCLES consecutive synchronized samples differ from it; any matching sample clears the counter.
REQ-012 First pulse latency SHALL be exactly DB_CYCLES+3 rising edges after the raw input is first sampled at the new level (7 with defaults).
REQ-013 At most one of up/down/load SHALL be 1 in any cycle; every pulse SHALL be exactly one cycle wide.
REQ-014 Arbitration on simultaneous debounced presses SHALL be load > down > up.
REQ-015 FSM states: IDLE, FIRST, HOLD_WAIT, REPEAT.
REQ-016 IDLE -> FIRST on a debounced rising edge of an arbitrated button; that button is captured as the active direction.
REQ-017 FIRST: emit one pulse for the active button; -> HOLD_WAIT if still held, else -> IDLE.
REQ-018 HOLD_WAIT: count RPT_DELAY cycles from the first pulse; -> REPEAT and emit a pulse on expiry; -> IDLE on release.
REQ-019 REPEAT: emit a pulse every RPT_RATE cycles while held; -> IDLE on release.
REQ-020 Load SHALL never auto-repeat: after the load pulse, FSM waits (no pulses) until btn_ld debounced release, then -> IDLE.
REQ-021 A debounced load press SHALL preempt any up/down hold in any state: next cycle is FIRST with load active.
REQ-022 Presses of the non-active direction during a hold SHALL be ignored; they are honoured only as a fresh rising edge seen from IDLE.
REQ-023 Limit suppression: up pulses (first and repeat) SHALL be masked while high=1; down pulses masked while low=1; timers keep running, state unchanged.
REQ-024 in_val SHALL be loaded from sw_in in the same cycle load is asserted and SHALL hold its value otherwise.
REQ-025 Counter widths: debounce counter ceil(log2(DB_CYCLES+1)) bits; repeat timer sized for max(RPT_DELAY,RPT_RATE); no wrap permitted.

Reset
REQ-026 rst=1 SHALL, at the next edge, clear synchronizers, debounced levels, debounce counters, timers, FSM to IDLE, up/down/load=0, in_val=5'b00000.
REQ-027 rst has priority over every other input, including a pulse in progress.
REQ-028 A button still held when rst deasserts SHALL be treated as a new press and fully re-debounced (first pulse again DB_CYCLES+3 edges later).

Verification (defaults DB_CYCLES=4, RPT_DELAY=8, RPT_RATE=3; cycle 0 = first edge sampling the raw level)
REQ-029 Glitch: btn_up=1 for 3 cycles then 0 -> no up pulse ever.
REQ-030 Hold: btn_up=1 for 30 cycles, high=0 -> up pulses at cycles 7, 15, 18, 21, 24, 27, 30, then none after release is debounced.
REQ-031 Limit: btn_dn held, low=1 from cycle 14 -> down at 7 only; pulse at 15 and later suppressed; low=0 at cycle 20 -> next down at 21.
REQ-032 Load: sw_in=5'b10110, btn_ld held 40 cycles -> exactly one load at cycle 7 with in_val=5'b10110 that cycle; no further pulses.
REQ-033 Simultaneous: btn_up and btn_dn rise same cycle and held -> only down pulses, same timing as REQ-030.
REQ-034 Reset mid-repeat: rst=1 at cycle 19 for 1 cycle, btn_up still held -> all outputs 0 from cycle 20; next up pulse 7 edges after rst deasserts.

Source files
------------

// File: rtl/updn_cmd_gen.sv
// Push-button front end for an up/down counter: synchronizes and debounces three buttons,
// arbitrates them and issues single-cycle up/down/load commands with hold-to-repeat.
module updn_cmd_gen #(
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned RPT_DELAY = 8,
   parameter int unsigned RPT_RATE  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_dn,
   input  logic       btn_ld,
   input  logic [4:0] sw_in,
   input  logic       high,
   input  logic       low,
   output logic       up,
   output logic       down,
   output logic       load,
   output logic [4:0] in_val
);

   localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
   localparam int unsigned TmrMax = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int unsigned TmrW   = $clog2(TmrMax + 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] FIRST     = 2'd1;
   localparam logic [1:0] HOLD_WAIT = 2'd2;
   localparam logic [1:0] REPEAT    = 2'd3;

   // Active-direction codes double as bit indices into the button vectors.
   localparam logic [1:0] DirUp = 2'd0;
   localparam logic [1:0] DirDn = 2'd1;
   localparam logic [1:0] DirLd = 2'd2;

   logic [2:0]           raw;
   logic [2:0]           sync1_q, sync2_q;
   logic [2:0]           db_q, db_prev_q;
   logic [2:0][DbW-1:0]  db_cnt_q;
   logic [2:0]           rise;

   logic [1:0]           state_q, state_d;
   logic [1:0]           dir_q, dir_d;
   logic [TmrW-1:0]      tmr_q, tmr_d;
   logic                 held;
   logic                 fire;
   logic                 up_d, down_d, load_d;

   assign raw  = {btn_ld, btn_dn, btn_up};
   assign rise = db_q & ~db_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         db_cnt_q  <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
               db_q[i]     <= ~db_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      held = 1'b0;
      case (dir_q)
         DirUp:   held = db_q[0];
         DirDn:   held = db_q[1];
         DirLd:   held = db_q[2];
         default: held = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      tmr_d   = tmr_q;
      fire    = 1'b0;
      // A fresh load press overrides whatever the FSM is doing.
      if (rise[2]) begin
         state_d = FIRST;
         dir_d   = DirLd;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise[1]) begin
                  state_d = FIRST;
                  dir_d   = DirDn;
               end else if (rise[0]) begin
                  state_d = FIRST;
                  dir_d   = DirUp;
               end
            end
            FIRST: begin
               fire    = 1'b1;
               tmr_d   = '0;
               state_d = held ? HOLD_WAIT : IDLE;
            end
            HOLD_WAIT: begin
               if (!held) begin
                  state_d = IDLE;
               end else if (dir_q != DirLd) begin
                  if (tmr_q == TmrW'(RPT_DELAY - 1)) begin
                     fire    = 1'b1;
                     tmr_d   = '0;
                     state_d = REPEAT;
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (!held) begin
                  state_d = IDLE;
               end else if (tmr_q == TmrW'(RPT_RATE - 1)) begin
                  fire  = 1'b1;
                  tmr_d = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Limit flags only mask the pulse; the timers above keep running.
   assign up_d   = fire & (dir_q == DirUp) & ~high;
   assign down_d = fire & (dir_q == DirDn) & ~low;
   assign load_d = fire & (dir_q == DirLd);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= DirUp;
         tmr_q   <= '0;
         up      <= 1'b0;
         down    <= 1'b0;
         load    <= 1'b0;
         in_val  <= 5'b00000;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         tmr_q   <= tmr_d;
         up      <= up_d;
         down    <= down_d;
         load    <= load_d;
         if (load_d) begin
            in_val <= sw_in;
         end
      end
   end

endmodule

// File: tb/tb_updn_cmd_gen.sv
// Self-checking bench for updn_cmd_gen: directed timing scenarios plus randomized button
// activity, all compared every cycle against a behavioural reference model.
module tb_updn_cmd_gen;

   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_dn, btn_ld;
   logic [4:0] sw_in;
   logic       high, low;
   logic       up, down, load;
   logic [4:0] in_val;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [63:0] up_seen, dn_seen, ld_seen;
   logic [4:0]  ld_val;

   // Reference model state
   logic [1:0]  rhist [3];
   logic [31:0] shist [3];
   int          nval  [3];
   logic        mdb   [3];
   logic        mdbp  [3];
   int          mmode;
   int          mdir;
   int          mn;
   logic        e_up, e_dn, e_ld;
   logic [4:0]  e_val;

   updn_cmd_gen #(
      .DB_CYCLES (DB),
      .RPT_DELAY (RD),
      .RPT_RATE  (RR)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_up (btn_up),
      .btn_dn (btn_dn),
      .btn_ld (btn_ld),
      .sw_in  (sw_in),
      .high   (high),
      .low    (low),
      .up     (up),
      .down   (down),
      .load   (load),
      .in_val (in_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] win(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 3; b++) begin
         rhist[b] = 2'b00;
         shist[b] = '0;
         nval[b]  = 0;
         mdb[b]   = 1'b0;
         mdbp[b]  = 1'b0;
      end
      mmode = 0;
      mdir  = 0;
      mn    = 0;
      e_up  = 1'b0;
      e_dn  = 1'b0;
      e_ld  = 1'b0;
      e_val = 5'b00000;
   endfunction

   // One rising edge of the reference: command logic sees the pre-edge debounced levels,
   // then the debounced levels advance from the two-edge-delayed raw samples.
   function automatic void model_edge();
      logic [2:0] raw;
      logic       rise [3];
      logic       fire;
      logic       all_diff;
      logic       s2v;
      if (rst) begin
         model_reset();
         return;
      end
      raw  = {btn_ld, btn_dn, btn_up};
      for (int b = 0; b < 3; b++) rise[b] = mdb[b] & ~mdbp[b];
      fire = 1'b0;
      if (rise[2]) begin
         mmode = 1;
         mdir  = 2;
      end else if (mmode == 0) begin
         if (rise[1]) begin
            mmode = 1;
            mdir  = 1;
         end else if (rise[0]) begin
            mmode = 1;
            mdir  = 0;
         end
      end else if (mmode == 1) begin
         fire  = 1'b1;
         mn    = 0;
         mmode = mdb[mdir] ? 2 : 0;
      end else begin
         if (!mdb[mdir]) begin
            mmode = 0;
         end else begin
            mn++;
            if (mdir != 2 && mn >= RD && ((mn - RD) % RR) == 0) fire = 1'b1;
         end
      end
      e_up = fire && mdir == 0 && !high;
      e_dn = fire && mdir == 1 && !low;
      e_ld = fire && mdir == 2;
      if (e_ld) e_val = sw_in;

      for (int b = 0; b < 3; b++) begin
         mdbp[b]  = mdb[b];
         s2v      = rhist[b][1];
         rhist[b] = {rhist[b][0], raw[b]};
         shist[b] = {shist[b][30:0], s2v};
         if (nval[b] < 1000) nval[b]++;
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++) if (shist[b][j] == mdb[b]) all_diff = 1'b0;
         if (nval[b] >= DB && all_diff) begin
            mdb[b]  = ~mdb[b];
            nval[b] = 0;
         end
      end
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("up",     64'(up),     64'(e_up));
      check("down",   64'(down),   64'(e_dn));
      check("load",   64'(load),   64'(e_ld));
      check("in_val", 64'(in_val), 64'(e_val));
      check("onehot", 64'(int'(up) + int'(down) + int'(load) > 1), 64'd0);
      if (cyc >= 0 && cyc < 64) begin
         up_seen[cyc] = up;
         dn_seen[cyc] = down;
         ld_seen[cyc] = load;
         if (load) ld_val = in_val;
      end
      cyc++;
   endtask

   task automatic scen_begin();
      btn_up = 1'b0;
      btn_dn = 1'b0;
      btn_ld = 1'b0;
      high   = 1'b0;
      low    = 1'b0;
      rst    = 1'b1;
      step();
      rst    = 1'b0;
      step();
      cyc     = 0;
      up_seen = '0;
      dn_seen = '0;
      ld_seen = '0;
      ld_val  = '0;
   endtask

   initial begin
      logic [63:0] e;
      logic [2:0]  lvl;
      int          dur [3];

      btn_up = 1'b0;
      btn_dn = 1'b0;
      btn_ld = 1'b0;
      sw_in  = 5'b00000;
      high   = 1'b0;
      low    = 1'b0;
      rst    = 1'b1;
      model_reset();
      step();
      check("reset_up",     64'(up),     64'd0);
      check("reset_in_val", 64'(in_val), 64'd0);

      // Short glitch never produces a pulse
      scen_begin();
      for (int i = 0; i < 25; i++) begin
         btn_up = (i < 3);
         step();
      end
      check("glitch_up", up_seen & win(0, 24), 64'd0);

      // Hold up for 30 cycles
      scen_begin();
      for (int i = 0; i < 61; i++) begin
         btn_up = (i < 30);
         step();
      end
      e = '0;
      e[7] = 1'b1; e[15] = 1'b1; e[18] = 1'b1; e[21] = 1'b1;
      e[24] = 1'b1; e[27] = 1'b1; e[30] = 1'b1;
      check("hold_up_pulses", up_seen & win(0, 30), e);
      check("hold_up_after_release", up_seen & win(36, 60), 64'd0);

      // Down held with low limit asserted for cycles 14..19
      scen_begin();
      for (int i = 0; i < 25; i++) begin
         btn_dn = 1'b1;
         low    = (i >= 14 && i < 20);
         step();
      end
      e = '0;
      e[7] = 1'b1; e[21] = 1'b1; e[24] = 1'b1;
      check("limit_dn_pulses", dn_seen & win(0, 24), e);

      // Load held 40 cycles: one pulse only
      scen_begin();
      sw_in = 5'b10110;
      for (int i = 0; i < 55; i++) begin
         btn_ld = (i < 40);
         step();
      end
      e = '0;
      e[7] = 1'b1;
      check("load_pulses", ld_seen & win(0, 54), e);
      check("load_in_val", 64'(ld_val), 64'(5'b10110));
      check("load_in_val_hold", 64'(in_val), 64'(5'b10110));

      // Up and down rise together: down wins
      scen_begin();
      for (int i = 0; i < 31; i++) begin
         btn_up = 1'b1;
         btn_dn = 1'b1;
         step();
      end
      e = '0;
      e[7] = 1'b1; e[15] = 1'b1; e[18] = 1'b1; e[21] = 1'b1;
      e[24] = 1'b1; e[27] = 1'b1; e[30] = 1'b1;
      check("simul_dn_pulses", dn_seen & win(0, 30), e);
      check("simul_up_none", up_seen & win(0, 30), 64'd0);

      // Reset mid-repeat with button still held
      scen_begin();
      for (int i = 0; i < 31; i++) begin
         btn_up = 1'b1;
         rst    = (i == 19);
         step();
      end
      rst = 1'b0;
      e = '0;
      e[7] = 1'b1; e[15] = 1'b1; e[18] = 1'b1; e[27] = 1'b1;
      check("rst_mid_repeat_pulses", up_seen & win(0, 30), e);

      // Randomized activity
      scen_begin();
      lvl = 3'b000;
      for (int b = 0; b < 3; b++) dur[b] = $urandom_range(0, 20);
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 3; b++) begin
            if (dur[b] == 0) begin
               lvl[b] = ~lvl[b];
               dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                    : $urandom_range(5, 60);
            end else begin
               dur[b]--;
            end
         end
         btn_up = lvl[0];
         btn_dn = lvl[1];
         btn_ld = lvl[2];
         if ($urandom_range(0, 24) == 0) high = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) low = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) sw_in = 5'($urandom);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
